truth_table_sweeper: RTL and testbench

- Upstream stimulus-and-capture stage for a 3-input combinational logic block (one output, truth-table-specified gate circuit).
- On start, drives all 8 input combinations in ascending order, holds each for a settle window and samples the block's output.
- Assembles the measured 8-bit truth table in the codebase's hex truth-table encoding and compares it against an expected table.
- Used as the on-chip/bench harness that feeds in1..in3 and consumes out.

---
 rtl/truth_table_sweeper.sv | 160 ++++++++++++++++
 tb/tb_truth_table_sweeper.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Stimulus-and-capture harness for a 3-input, 1-output logic block: sweeps all
// eight input vectors, samples the synchronized response and checks the table.
module truth_table_sweeper #(
    parameter int          SETTLE_CYCLES = 16,
    parameter logic [7:0]  EXPECTED      = 8'h9A,
    parameter int          CNT_W         = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       abort,
    output logic       in1,
    output logic       in2,
    output logic       in3,
    input  logic       dut_out,
    output logic       busy,
    output logic       done,
    output logic [7:0] table_out,
    output logic       pass,
    output logic [7:0] mismatch_mask
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_idx;
    logic [2:0]       r_vec;
    logic [7:0]       r_work;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_busy;
    logic             r_done;
    logic [7:0]       r_table;
    logic             r_pass;
    logic [7:0]       r_mask;

    logic             w_last;
    logic [7:0]       w_work_next;

    // Working table with the current vector's bit (idx 0 -> bit 7) replaced by the sample.
    function automatic logic [7:0] f_insert(input logic [7:0] tab, input logic [2:0] idx,
                                            input logic smp);
        logic [7:0] res;
        res = tab;
        res[3'd7 - idx] = smp;
        return res;
    endfunction

    assign w_last = (r_cnt == LP_LAST);

    // Next working-table value if the current cycle ends a settle window.
    always_comb begin
        w_work_next = r_work;
        if (r_state == ST_RUN) begin
            w_work_next = f_insert(r_work, r_idx, r_sync2);
        end else begin
            w_work_next = r_work;
        end
    end

    // Two-flop synchronizer for the asynchronous block output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= dut_out;
            r_sync2 <= r_sync1;
        end
    end

    // Sweep controller; every output is a register so the drive lines cannot glitch.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= 3'd0;
            r_vec   <= 3'd0;
            r_work  <= 8'h00;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_table <= 8'h00;
            r_pass  <= 1'b0;
            r_mask  <= 8'h00;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    r_vec  <= 3'd0;
                    r_cnt  <= '0;
                    r_idx  <= 3'd0;
                    if (start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_work  <= 8'h00;
                    end else begin
                        r_busy  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        // Abort beats a coinciding final sample; results stay untouched.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_vec   <= 3'd0;
                        r_cnt   <= '0;
                        r_idx   <= 3'd0;
                    end else if (w_last) begin
                        r_cnt  <= '0;
                        r_work <= w_work_next;
                        if (r_idx == 3'd7) begin
                            r_state <= ST_FINISH;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_table <= w_work_next;
                            r_pass  <= (w_work_next == EXPECTED);
                            r_mask  <= w_work_next ^ EXPECTED;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                            r_vec <= r_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_vec   <= 3'd0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_vec   <= 3'd0;
                    r_cnt   <= '0;
                    r_idx   <= 3'd0;
                end
            endcase
        end
    end

    assign in1           = r_vec[2];
    assign in2           = r_vec[1];
    assign in3           = r_vec[0];
    assign busy          = r_busy;
    assign done          = r_done;
    assign table_out     = r_table;
    assign pass          = r_pass;
    assign mismatch_mask = r_mask;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Bench for truth_table_sweeper: plays the logic block (ideal, faulty, lagged,
// random) and checks timing and captured tables against a reference model.
module tb_truth_table_sweeper;

    localparam int         S   = 4;
    localparam logic [7:0] EXP = 8'h9A;

    logic       clk = 1'b0;
    logic       rst, start, abort;
    logic       in1, in2, in3, dut_out;
    logic       busy, done, pass;
    logic [7:0] table_out, mismatch_mask;

    logic [7:0] fn;
    int         lag;
    bit         fen;
    logic [2:0] fidx;
    bit         fval;
    logic [2:0] pipe [0:3];
    logic [2:0] m_vec;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    truth_table_sweeper #(.SETTLE_CYCLES(S), .EXPECTED(EXP), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .in1(in1), .in2(in2), .in3(in3), .dut_out(dut_out),
        .busy(busy), .done(done), .table_out(table_out), .pass(pass),
        .mismatch_mask(mismatch_mask)
    );

    always #5 clk = ~clk;

    // Behavioural block under test: table lookup, optional stuck fault, L-cycle lag.
    always @(posedge clk) begin
        pipe[0] <= {in1, in2, in3};
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end

    always_comb begin
        m_vec   = (lag == 0) ? {in1, in2, in3} : pipe[(lag > 0) ? lag - 1 : 0];
        dut_out = fn[3'd7 - m_vec];
        if (fen && m_vec == fidx) dut_out = fval;
    end

    // Sample for vector k reflects the inputs applied (k+1)*S-3-lag cycles after start.
    function automatic logic [7:0] ref_table(input logic [7:0] f, input int l, input bit fe,
                                             input logic [2:0] fi, input bit fv);
        logic [7:0] r;
        int t, v;
        logic o;
        for (int k = 0; k < 8; k++) begin
            t = (k + 1) * S - 3 - l;
            v = (t < 0) ? 0 : t / S;
            o = f[7 - v];
            if (fe && v == int'(fi)) o = fv;
            r[7 - k] = o;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Walks one sweep from the cycle after its start edge through the return to IDLE.
    task automatic follow(input logic [7:0] exp_tab, input int pulse_at);
        for (int n = 1; n <= 8 * S + 2; n++) begin
            if (pulse_at > 0 && n == pulse_at) start = 1'b1;
            else if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            if (n <= 8 * S)
                check("run", {3'b000, busy, done, in1, in2, in3},
                      {3'b000, 1'b1, 1'b0, 3'((n - 1) / S)});
            else if (n == 8 * S + 1) begin
                check("done_pulse", {6'd0, busy, done}, 8'h01);
                check("table", table_out, exp_tab);
                check("pass", {7'd0, pass}, {7'd0, exp_tab == EXP});
                check("mask", mismatch_mask, exp_tab ^ EXP);
            end else
                check("idle", {3'b000, busy, done, in1, in2, in3}, 8'h00);
            @(negedge clk);
        end
    endtask

    // Stops a sweep at cycle 'at' with abort (or rst) and checks nothing completes.
    task automatic interrupt(input int at, input bit use_rst, input logic [7:0] prev_tab);
        int dones;
        launch(1'b0);
        for (int n = 1; n <= at; n++) begin
            check("pre_int", {3'b000, busy, done, in1, in2, in3},
                  {3'b000, 1'b1, 1'b0, 3'((n - 1) / S)});
            if (n == at) begin
                if (use_rst) rst = 1'b1;
                else abort = 1'b1;
            end
            @(negedge clk);
        end
        rst = 1'b0;
        abort = 1'b0;
        check("int_state", {3'b000, busy, done, in1, in2, in3}, 8'h00);
        check("int_table", table_out, prev_tab);
        check("int_pass", {7'd0, pass}, {7'd0, prev_tab == EXP});
        check("int_mask", mismatch_mask, use_rst ? 8'h00 : (prev_tab ^ EXP));
        dones = 0;
        for (int i = 0; i < 10 * S; i++) begin
            if (done) dones++;
            @(negedge clk);
        end
        check("no_done", 8'(dones), 8'd0);
    endtask

    initial begin
        logic [7:0] e;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        fn = EXP; lag = 0; fen = 1'b0; fidx = 3'd0; fval = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ctl", {3'b000, busy, done, in1, in2, in3}, 8'h00);
        check("rst_table", table_out, 8'h00);
        check("rst_pass", {7'd0, pass}, 8'h00);
        check("rst_mask", mismatch_mask, 8'h00);

        // Ideal block.
        launch(1'b0); follow(8'h9A, 0);

        // Output stuck at 1 for vector 101.
        fen = 1'b1; fidx = 3'd5; fval = 1'b1;
        e = ref_table(fn, lag, fen, fidx, fval);
        check("ref_fault", e, 8'h9E);
        launch(1'b0); follow(e, 0);
        fen = 1'b0;

        // Lag within tolerance, then one cycle beyond.
        lag = 1; repeat (5) @(negedge clk);
        launch(1'b0); follow(8'h9A, 0);
        lag = 2; repeat (5) @(negedge clk);
        e = ref_table(fn, lag, 1'b0, 3'd0, 1'b0);
        check("ref_lag2_differs", {7'd0, e != 8'h9A}, 8'h01);
        launch(1'b0); follow(e, 0);
        lag = 0; repeat (5) @(negedge clk);

        // Abort keeps the previous result; rst clears it.
        launch(1'b0); follow(8'h9A, 0);
        interrupt(10, 1'b0, 8'h9A);
        interrupt(20, 1'b1, 8'h00);
        launch(1'b0); follow(8'h9A, 0);

        // A start pulse during a sweep is ignored.
        launch(1'b0); follow(8'h9A, 5);

        // Start held high: back-to-back sweeps.
        launch(1'b1); follow(8'h9A, 0);
        start = 1'b0;
        follow(8'h9A, 0);

        // Randomized blocks.
        for (int r = 0; r < 6; r++) begin
            fn   = 8'($urandom);
            lag  = $urandom_range(0, 3);
            fen  = 1'($urandom_range(0, 1));
            fidx = 3'($urandom_range(0, 7));
            fval = 1'($urandom_range(0, 1));
            repeat (4 + $urandom_range(0, 3)) @(negedge clk);
            e = ref_table(fn, lag, fen, fidx, fval);
            launch(1'b0); follow(e, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
